// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase timer: FSM states, lamp codes
// and small elaboration-time helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_NS_G  = 3'b000,
        ST_NS_Y  = 3'b001,
        ST_AR1   = 3'b010,
        ST_EW_G  = 3'b011,
        ST_EW_Y  = 3'b100,
        ST_AR2   = 3'b101,
        ST_FLASH = 3'b110
    } state_e;

    // One-hot lamp codes {red, yellow, green}
    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    function automatic int max5(input int a, input int b, input int c,
                                input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    function automatic state_e next_phase(input state_e s);
        case (s)
            ST_NS_G: return ST_NS_Y;
            ST_NS_Y: return ST_AR1;
            ST_AR1:  return ST_EW_G;
            ST_EW_G: return ST_EW_Y;
            ST_EW_Y: return ST_AR2;
            default: return ST_NS_G;
        endcase
    endfunction

endpackage

// File: rtl/phase_down_counter.sv
// Loadable seconds down-counter; flags the final second of a phase.
module phase_down_counter #(
    parameter int              W       = 5,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)     count_d = load_val;
        else if (dec) count_d = count_q - W'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) count_q <= RST_VAL;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign last  = (count_q == W'(1));

endmodule

// File: rtl/light_phase_timer.sv
// Two-way intersection phase sequencer driven by the seconds tick, with a
// night flash mode; lamps and phase_done are registered off the next state.
module light_phase_timer
    import traffic_pkg::*;
#(
    parameter  int NS_GREEN_SEC  = 20,
    parameter  int NS_YELLOW_SEC = 3,
    parameter  int EW_GREEN_SEC  = 15,
    parameter  int EW_YELLOW_SEC = 3,
    parameter  int ALL_RED_SEC   = 2,
    localparam int CNT_W = $clog2(max5(NS_GREEN_SEC, NS_YELLOW_SEC, EW_GREEN_SEC,
                                       EW_YELLOW_SEC, ALL_RED_SEC) + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             sec_tick,
    input  logic             night_mode,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] remain_sec,
    output logic             phase_done
);

    if (NS_GREEN_SEC < 1 || NS_YELLOW_SEC < 1 || EW_GREEN_SEC < 1 ||
        EW_YELLOW_SEC < 1 || ALL_RED_SEC < 1) begin : g_bad_duration
        $error("light_phase_timer: every phase duration must be at least 1 second");
    end

    localparam logic [CNT_W-1:0] NS_G_C = CNT_W'(NS_GREEN_SEC);
    localparam logic [CNT_W-1:0] NS_Y_C = CNT_W'(NS_YELLOW_SEC);
    localparam logic [CNT_W-1:0] EW_G_C = CNT_W'(EW_GREEN_SEC);
    localparam logic [CNT_W-1:0] EW_Y_C = CNT_W'(EW_YELLOW_SEC);
    localparam logic [CNT_W-1:0] AR_C   = CNT_W'(ALL_RED_SEC);

    function automatic logic [CNT_W-1:0] duration(input state_e s);
        case (s)
            ST_NS_G: return NS_G_C;
            ST_NS_Y: return NS_Y_C;
            ST_EW_G: return EW_G_C;
            ST_EW_Y: return EW_Y_C;
            ST_AR1,
            ST_AR2:  return AR_C;
            default: return '0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic             flash_q, flash_d;
    logic             done_q, done_d;
    logic [2:0]       ns_q, ns_d, ew_q, ew_d;
    logic             tick_q;
    logic             cnt_load, cnt_dec, cnt_last;
    logic [CNT_W-1:0] cnt_val, cnt_count;
    state_e           nxt;

    assign tick_q = sec_tick & en;
    assign nxt    = next_phase(state_q);

    // night_mode is checked before expiry so a coincident tick enters FLASH
    always_comb begin
        state_d  = state_q;
        flash_d  = flash_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        if (tick_q) begin
            if (state_q == ST_FLASH) begin
                if (!night_mode) begin
                    state_d  = ST_AR2;
                    flash_d  = 1'b0;
                    done_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = AR_C;
                end else begin
                    flash_d = ~flash_q;
                end
            end else if (night_mode) begin
                state_d  = ST_FLASH;
                flash_d  = 1'b1;
                done_d   = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = '0;
            end else if (cnt_last) begin
                state_d  = nxt;
                done_d   = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = duration(nxt);
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    always_comb begin
        ns_d = LIGHT_R;
        ew_d = LIGHT_R;
        case (state_d)
            ST_NS_G:  ns_d = LIGHT_G;
            ST_NS_Y:  ns_d = LIGHT_Y;
            ST_EW_G:  ew_d = LIGHT_G;
            ST_EW_Y:  ew_d = LIGHT_Y;
            ST_FLASH: begin
                ns_d = flash_d ? LIGHT_Y : LIGHT_OFF;
                ew_d = flash_d ? LIGHT_Y : LIGHT_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_AR2;
            flash_q <= 1'b0;
            done_q  <= 1'b0;
            ns_q    <= LIGHT_R;
            ew_q    <= LIGHT_R;
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
            done_q  <= done_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
        end
    end

    phase_down_counter #(
        .W       (CNT_W),
        .RST_VAL (AR_C)
    ) u_cnt (
        .clk      (clk),
        .rstb     (rstb),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .last     (cnt_last)
    );

    assign ns_light   = ns_q;
    assign ew_light   = ew_q;
    assign remain_sec = cnt_count;
    assign phase_done = done_q;

endmodule

// File: tb/tb_light_phase_timer.sv
// Directed test-plan scenarios plus a randomized run against a phase-table
// reference model of the intersection timer.
module tb_light_phase_timer;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       en = 1'b0;
    logic       sec_tick = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic [4:0] remain_sec;
    logic       phase_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    light_phase_timer dut (
        .clk        (clk),
        .rstb       (rstb),
        .en         (en),
        .sec_tick   (sec_tick),
        .night_mode (night_mode),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .remain_sec (remain_sec),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    // Reference model: phase index into a table of (duration, ns lamp, ew lamp)
    int         dur_tab [6] = '{20, 3, 2, 15, 3, 2};
    logic [2:0] ns_tab  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab  [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int m_idx, m_rem;
    bit m_flash, m_fbit, m_done;

    task automatic model_reset();
        m_idx = 5; m_rem = 2; m_flash = 0; m_fbit = 0; m_done = 0;
    endtask

    task automatic model_tick(input bit night);
        if (m_flash) begin
            if (!night) begin
                m_flash = 0; m_fbit = 0; m_idx = 5; m_rem = dur_tab[5]; m_done = 1;
            end else m_fbit = ~m_fbit;
        end else if (night) begin
            m_flash = 1; m_fbit = 1; m_rem = 0; m_done = 1;
        end else if (m_rem == 1) begin
            m_idx = (m_idx + 1) % 6; m_rem = dur_tab[m_idx]; m_done = 1;
        end else m_rem = m_rem - 1;
    endtask

    function automatic logic [2:0] exp_ns();
        return m_flash ? (m_fbit ? 3'b010 : 3'b000) : ns_tab[m_idx];
    endfunction
    function automatic logic [2:0] exp_ew();
        return m_flash ? (m_fbit ? 3'b010 : 3'b000) : ew_tab[m_idx];
    endfunction

    // One clock: inputs held across the edge, model advanced, outputs settle
    task automatic cyc(input bit tick, input bit e, input bit night);
        sec_tick = tick; en = e; night_mode = night;
        @(posedge clk);
        m_done = 0;
        if (!rstb) model_reset();
        else if (tick && e) model_tick(night);
        #1;
        if (phase_done) done_cnt++;
    endtask

    task automatic tick10(input bit e, input bit night);
        cyc(1'b1, e, night);
        repeat (9) cyc(1'b0, e, night);
    endtask

    task automatic test_reset();
        rstb = 1'b0; model_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        total++; if (ns_light !== 3'b100) begin bad++; $display("FAIL reset_ns got=%b exp=100", ns_light); end
        total++; if (ew_light !== 3'b100) begin bad++; $display("FAIL reset_ew got=%b exp=100", ew_light); end
        total++; if (remain_sec !== 5'd2) begin bad++; $display("FAIL reset_remain got=%0d exp=2", remain_sec); end
        total++; if (phase_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", phase_done); end
        rstb = 1'b1;
    endtask

    task automatic test_full_cycle();
        done_cnt = 0;
        tick10(1'b1, 1'b0);
        total++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain_sec !== 5'd1) begin
            bad++; $display("FAIL ar2_tick1 got ns=%b ew=%b rem=%0d exp 100/100/1", ns_light, ew_light, remain_sec); end
        tick10(1'b1, 1'b0);
        total++; if (ns_light !== 3'b001 || ew_light !== 3'b100 || remain_sec !== 5'd20) begin
            bad++; $display("FAIL enter_ns_g got ns=%b ew=%b rem=%0d exp 001/100/20", ns_light, ew_light, remain_sec); end
        repeat (43) tick10(1'b1, 1'b0);
        total++; if (done_cnt !== 6) begin bad++; $display("FAIL cycle_done_clks got=%0d exp=6", done_cnt); end
        total++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain_sec !== 5'd2) begin
            bad++; $display("FAIL cycle_back_ar2 got ns=%b ew=%b rem=%0d exp 100/100/2", ns_light, ew_light, remain_sec); end
    endtask

    task automatic test_countdown();
        repeat (2) tick10(1'b1, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            tick10(1'b1, 1'b0);
            total++; if (remain_sec !== 5'(20 - k) || ns_light !== 3'b001 || ew_light !== 3'b100) begin
                bad++; $display("FAIL ns_g_count k=%0d got rem=%0d ns=%b ew=%b exp rem=%0d 001/100",
                                k, remain_sec, ns_light, ew_light, 20 - k); end
        end
        tick10(1'b1, 1'b0);
        total++; if (ns_light !== 3'b010 || ew_light !== 3'b100 || remain_sec !== 5'd3) begin
            bad++; $display("FAIL enter_ns_y got ns=%b ew=%b rem=%0d exp 010/100/3", ns_light, ew_light, remain_sec); end
    endtask

    task automatic test_enable_freeze();
        int d0;
        repeat (3 + 2 + 8) tick10(1'b1, 1'b0);
        total++; if (remain_sec !== 5'd7 || ew_light !== 3'b001) begin
            bad++; $display("FAIL ew_g_at7 got rem=%0d ew=%b exp 7/001", remain_sec, ew_light); end
        d0 = done_cnt;
        repeat (5) tick10(1'b0, 1'b1);
        total++; if (remain_sec !== 5'd7 || ns_light !== 3'b100 || ew_light !== 3'b001 || done_cnt !== d0) begin
            bad++; $display("FAIL en_freeze got rem=%0d ns=%b ew=%b done+=%0d exp 7/100/001/0",
                            remain_sec, ns_light, ew_light, done_cnt - d0); end
        tick10(1'b1, 1'b0);
        total++; if (remain_sec !== 5'd6) begin bad++; $display("FAIL en_resume got=%0d exp=6", remain_sec); end
    endtask

    task automatic test_night();
        repeat (6 + 3 + 2 + 20 + 2) tick10(1'b1, 1'b0);
        total++; if (ns_light !== 3'b010 || remain_sec !== 5'd1) begin
            bad++; $display("FAIL ns_y_last got ns=%b rem=%0d exp 010/1", ns_light, remain_sec); end
        cyc(1'b1, 1'b1, 1'b1);
        total++; if (ns_light !== 3'b010 || ew_light !== 3'b010 || remain_sec !== 5'd0 || phase_done !== 1'b1) begin
            bad++; $display("FAIL flash_entry got ns=%b ew=%b rem=%0d done=%b exp 010/010/0/1",
                            ns_light, ew_light, remain_sec, phase_done); end
        repeat (9) cyc(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick10(1'b1, 1'b1);
            total++; if (ns_light !== ((k % 2) ? 3'b000 : 3'b010) || ew_light !== ns_light || remain_sec !== 5'd0) begin
                bad++; $display("FAIL flash_toggle k=%0d got ns=%b ew=%b rem=%0d", k, ns_light, ew_light, remain_sec); end
        end
    endtask

    task automatic test_exit_flash();
        cyc(1'b1, 1'b1, 1'b0);
        total++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain_sec !== 5'd2 || phase_done !== 1'b1) begin
            bad++; $display("FAIL flash_exit got ns=%b ew=%b rem=%0d done=%b exp 100/100/2/1",
                            ns_light, ew_light, remain_sec, phase_done); end
        repeat (9) cyc(1'b0, 1'b1, 1'b0);
        repeat (2) tick10(1'b1, 1'b0);
        total++; if (ns_light !== 3'b001 || remain_sec !== 5'd20) begin
            bad++; $display("FAIL after_exit got ns=%b rem=%0d exp 001/20", ns_light, remain_sec); end
    endtask

    task automatic test_async_reset();
        repeat (20 + 3 + 2 + 15 + 1) tick10(1'b1, 1'b0);
        total++; if (ew_light !== 3'b010 || remain_sec !== 5'd2) begin
            bad++; $display("FAIL ew_y_mid got ew=%b rem=%0d exp 010/2", ew_light, remain_sec); end
        cyc(1'b1, 1'b1, 1'b0);
        #2 rstb = 1'b0;
        #1;
        total++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain_sec !== 5'd2 || phase_done !== 1'b0) begin
            bad++; $display("FAIL async_reset got ns=%b ew=%b rem=%0d done=%b exp 100/100/2/0",
                            ns_light, ew_light, remain_sec, phase_done); end
        model_reset();
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        rstb = 1'b1;
        repeat (2) tick10(1'b1, 1'b0);
        total++; if (ns_light !== 3'b001 || ew_light !== 3'b100 || remain_sec !== 5'd20) begin
            bad++; $display("FAIL restart got ns=%b ew=%b rem=%0d exp 001/100/20", ns_light, ew_light, remain_sec); end
    endtask

    task automatic test_random();
        bit night = 0;
        int shown = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) night = ~night;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, night);
            total++;
            if (ns_light !== exp_ns() || ew_light !== exp_ew() ||
                remain_sec !== 5'(m_rem) || phase_done !== m_done) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got ns=%b ew=%b rem=%0d done=%b exp ns=%b ew=%b rem=%0d done=%b",
                             i, ns_light, ew_light, remain_sec, phase_done, exp_ns(), exp_ew(), m_rem, m_done);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_countdown();
        test_enable_freeze();
        test_night();
        test_exit_flash();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
